// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// stall request polarity and the default stage indices of the core.
`ifndef PIPE_STALL_CTRL_PKG_SV
`define PIPE_STALL_CTRL_PKG_SV

`define Stop   1'b1
`define NoStop 1'b0

package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Slot numbering of the stall vector: bit 0 is the PC register.
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    localparam int unsigned DEF_N_STAGES    = STG_WB + 1;
    localparam int unsigned DEF_HOLD_STAGE  = STG_EX;
    localparam int unsigned DEF_CNT_W       = 6;
    localparam int unsigned DEF_PC_W        = 32;
    localparam int unsigned DEF_WDOG_CYCLES = 1024;

    localparam int unsigned PERF_STALL_W = 32;
    localparam int unsigned PERF_FLUSH_W = 16;

endpackage

`endif

// File: rtl/pipe_stall_ctrl_stall_watchdog.sv
// Stall-deadlock watchdog: saturating count of consecutive stall[0] cycles
// with a sticky timeout flag. WDOG_CYCLES = 0 builds no logic at all.
module stall_watchdog #(
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall0_i,
    input  logic flush_i,
    output logic timeout_o
);

    generate
        if (WDOG_CYCLES == 0) begin : g_off
            logic unused_wd;
            assign unused_wd = ^{clk, rst, stall0_i, flush_i};
            assign timeout_o = 1'b0;
        end else begin : g_on
            localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
            localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
            localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

            logic [WD_W-1:0] wd_cnt_q;
            logic            timeout_q;
            logic            counting;

            assign counting  = stall0_i && !flush_i;
            assign timeout_o = timeout_q;

            // Flag rises on the same edge the counter reaches WDOG_CYCLES.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt_q  <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    if (!counting) begin
                        wd_cnt_q <= '0;
                    end else if (wd_cnt_q != WD_MAX) begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                    if (counting && (wd_cnt_q == WD_LAST)) begin
                        timeout_q <= 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: merges stall requests into a thermometer stall
// vector and adds a timed hold, a registered flush/redirect and a watchdog.
// Optional performance counters are built when PIPE_STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned N_STAGES    = DEF_N_STAGES,
    parameter int unsigned HOLD_STAGE  = DEF_HOLD_STAGE,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned PC_W        = DEF_PC_W,
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_STAGES-1:0] stallreq_i,
    input  logic                hold_req_i,
    input  logic [CNT_W-1:0]    hold_cycles_i,
    input  logic                flush_req_i,
    input  logic [PC_W-1:0]     flush_pc_i,
    output logic [N_STAGES-1:0] stall_o,
    output logic                flush_o,
    output logic [PC_W-1:0]     new_pc_o,
    output logic                hold_busy_o,
    output logic                stall_timeout_o
`ifdef PIPE_STALL_PERF_CNT_EN
    ,
    output logic [PERF_STALL_W-1:0] stall_cycles_o,
    output logic [PERF_FLUSH_W-1:0] flush_count_o
`endif
);

    localparam logic [N_STAGES-1:0] HOLD_MASK =
        {N_STAGES{1'b1}} >> (N_STAGES - 1 - HOLD_STAGE);

    state_e            state_q;
    logic [CNT_W-1:0]  hold_cnt_q;
    logic              flush_q;
    logic [PC_W-1:0]   new_pc_q;

    logic [N_STAGES-1:0] req_vec;
    logic                hold_start;
    logic                hold_act;

    // Suffix-OR: a request at stage k freezes every older slot 0..k.
    always_comb begin
        logic acc;
        acc     = `NoStop;
        req_vec = '0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            acc        = acc | stallreq_i[i];
            req_vec[i] = acc;
        end
    end

    // First hold cycle comes straight from the request; a concurrent flush wins.
    assign hold_start = (state_q == ST_RUN) && hold_req_i && !flush_req_i &&
                        (hold_cycles_i != '0);
    assign hold_act   = !rst && !flush_q && ((state_q == ST_HOLD) || hold_start);

    always_comb begin
        stall_o = '0;
        if (!rst && !flush_q) begin
            stall_o = req_vec | (hold_act ? HOLD_MASK : '0);
        end
    end

    assign hold_busy_o = hold_act;
    assign flush_o     = flush_q;
    assign new_pc_o    = new_pc_q;

    // Control FSM; flush is accepted from every state and aborts a hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            flush_q <= flush_req_i;
            if (flush_req_i) begin
                new_pc_q <= flush_pc_i;
            end
            case (state_q)
                ST_RUN: begin
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                    end else if (hold_req_i && (hold_cycles_i >= CNT_W'(2))) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= hold_cycles_i - CNT_W'(2);
                    end
                end
                ST_HOLD: begin
                    if (flush_req_i) begin
                        state_q    <= ST_FLUSH;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state_q <= flush_req_i ? ST_FLUSH : ST_RUN;
                end
                default: begin
                    state_q    <= ST_RUN;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

    stall_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_stall_watchdog (
        .clk       (clk),
        .rst       (rst),
        .stall0_i  (stall_o[0]),
        .flush_i   (flush_q),
        .timeout_o (stall_timeout_o)
    );

`ifdef PIPE_STALL_PERF_CNT_EN
    logic [PERF_STALL_W-1:0] stall_cycles_q;
    logic [PERF_FLUSH_W-1:0] flush_count_q;

    // Free-running event counters, wrapping at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + PERF_STALL_W'(stall_o[0]);
            flush_count_q  <= flush_count_q + PERF_FLUSH_W'(flush_q);
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// random stimulus, compared cycle by cycle against a behavioural model.
module tb_pipe_stall_ctrl;

    localparam int N  = 6;
    localparam int CW = 6;
    localparam int PW = 32;
    localparam int WD = 8;
    localparam logic [N-1:0] HOLD_MASK = 6'b001111;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  stallreq;
    logic          hold_req;
    logic [CW-1:0] hold_cycles;
    logic          flush_req;
    logic [PW-1:0] flush_pc;
    logic [N-1:0]  stall;
    logic          flush;
    logic [PW-1:0] new_pc;
    logic          hold_busy;
    logic          stall_timeout;
`ifdef PIPE_STALL_PERF_CNT_EN
    logic [31:0]   stall_cycles;
    logic [15:0]   flush_count;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .N_STAGES    (N),
        .HOLD_STAGE  (3),
        .CNT_W       (CW),
        .PC_W        (PW),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_i      (stallreq),
        .hold_req_i      (hold_req),
        .hold_cycles_i   (hold_cycles),
        .flush_req_i     (flush_req),
        .flush_pc_i      (flush_pc),
        .stall_o         (stall),
        .flush_o         (flush),
        .new_pc_o        (new_pc),
        .hold_busy_o     (hold_busy),
        .stall_timeout_o (stall_timeout)
`ifdef PIPE_STALL_PERF_CNT_EN
        ,
        .stall_cycles_o  (stall_cycles),
        .flush_count_o   (flush_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remaining hold cycles, flush register, PC, watchdog run.
    int            hold_rem = 0;
    logic          flush_m  = 1'b0;
    logic [PW-1:0] pc_m     = '0;
    int            wd_m     = 0;
    logic          to_m     = 1'b0;
    logic          regs_ok  = 1'b0;
    logic [31:0]   sc_m     = '0;
    logic [15:0]   fc_m     = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] thermo(input logic [N-1:0] r);
        logic [N-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) t[i] = ((r >> i) != '0);
        return t;
    endfunction

    task automatic cyc(input logic r, input logic [N-1:0] sr, input logic hr,
                       input logic [CW-1:0] hc, input logic fr, input logic [PW-1:0] fp);
        logic         hold_now;
        logic [N-1:0] exp_stall;
        @(negedge clk);
        rst = r; stallreq = sr; hold_req = hr; hold_cycles = hc;
        flush_req = fr; flush_pc = fp;
        #1;
        hold_now  = !r && !flush_m && ((hold_rem > 0) || (hr && (hc != '0) && !fr));
        exp_stall = (r || flush_m) ? '0 : (thermo(sr) | (hold_now ? HOLD_MASK : '0));
        check("stall", 64'(stall), 64'(exp_stall));
        check("hold_busy", 64'(hold_busy), 64'(hold_now));
        if (regs_ok) begin
            check("flush", 64'(flush), 64'(flush_m));
            check("new_pc", 64'(new_pc), 64'(pc_m));
            check("stall_timeout", 64'(stall_timeout), 64'(to_m));
`ifdef PIPE_STALL_PERF_CNT_EN
            check("stall_cycles", 64'(stall_cycles), 64'(sc_m));
            check("flush_count", 64'(flush_count), 64'(fc_m));
`endif
        end
        @(posedge clk);
        if (r) begin
            regs_ok = 1'b1; hold_rem = 0; flush_m = 1'b0; pc_m = '0;
            wd_m = 0; to_m = 1'b0; sc_m = '0; fc_m = '0;
        end else begin
            if (exp_stall[0]) begin
                if (wd_m < WD) wd_m++;
                if (wd_m == WD) to_m = 1'b1;
            end else begin
                wd_m = 0;
            end
            sc_m = sc_m + 32'(exp_stall[0]);
            fc_m = fc_m + 16'(flush_m);
            if (fr)                hold_rem = 0;
            else if (hold_rem > 0) hold_rem--;
            else if (hold_now)     hold_rem = int'(hc) - 1;
            flush_m = fr;
            if (fr) pc_m = fp;
        end
    endtask

    task automatic idle(input int n, input logic [N-1:0] sr);
        for (int i = 0; i < n; i++) cyc(1'b0, sr, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [N-1:0] sr_cur;
        rst = 1'b1; stallreq = '0; hold_req = 1'b0; hold_cycles = '0;
        flush_req = 1'b0; flush_pc = '0;

        cyc(1'b1, '0, 1'b0, '0, 1'b0, '0);
        cyc(1'b1, '0, 1'b0, '0, 1'b0, '0);
        idle(1, '0);

        // Request merge patterns
        idle(1, 6'b000100);
        idle(1, 6'b010100);
        idle(1, 6'b000000);

        // Timed hold of 5 cycles; a second request in cycle 3 is ignored
        cyc(1'b0, '0, 1'b1, 6'd5, 1'b0, '0);
        idle(1, '0);
        cyc(1'b0, '0, 1'b1, 6'd5, 1'b0, '0);
        idle(4, '0);

        // Hold lengths 1 and 0
        cyc(1'b0, '0, 1'b1, 6'd1, 1'b0, '0);
        idle(2, '0);
        cyc(1'b0, '0, 1'b1, 6'd0, 1'b0, '0);
        idle(2, '0);

        // Flush during a hold, then back-to-back flushes
        cyc(1'b0, 6'b100000, 1'b1, 6'd10, 1'b0, '0);
        idle(2, 6'b100000);
        cyc(1'b0, 6'b100000, 1'b0, '0, 1'b1, 32'h0000_0100);
        idle(3, 6'b100000);
        cyc(1'b0, 6'b000010, 1'b1, 6'd4, 1'b1, 32'h0000_0200);
        cyc(1'b0, 6'b000010, 1'b0, '0, 1'b1, 32'h0000_0300);
        idle(3, 6'b000010);
        idle(2, '0);

        // Watchdog: rises on the 8th consecutive stall cycle, sticky until reset
        idle(11, 6'b000100);
        idle(3, '0);
        cyc(1'b1, '0, 1'b0, '0, 1'b0, '0);
        idle(2, '0);

        // Reset in the second cycle of a 10-cycle hold
        cyc(1'b0, '0, 1'b1, 6'd10, 1'b0, '0);
        cyc(1'b1, '0, 1'b0, '0, 1'b0, '0);
        idle(3, '0);

        // Random traffic with persistent stall-request runs
        sr_cur = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0)
                sr_cur = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            cyc(($urandom_range(0, 149) == 0), sr_cur,
                ($urandom_range(0, 5) == 0), CW'($urandom_range(0, 12)),
                ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
